ps2_kbd_tx: RTL
===============

Name: ps2_kbd_tx

Overview:
- Device-side PS/2 keyboard transmitter: the keyboard end of the PS/2 link. It serialises scan codes onto ps2_clk/ps2_data exactly as a real keyboard does.
- Used as a keyboard model in NPC simulation and for loopback tests against the host-side PS/2 receiver.
- Accepts {break flag, scan code} entries through a valid/ready handshake into a small FIFO.
- Emits one 11-bit frame per byte; break entries get an automatic 0xF0 prefix frame.

Parameters:
- HALF, 4: clk cycles per ps2_clk half-period (high phase and low phase each). Legal range ≥2.
- GAP, 8: clk cycles of idle (both lines high) after each frame's stop bit.
- DEPTH, 4: FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  entry offered this cycle.
- in_brk  input  1  1 = key release (send F0 then code); 0 = make (code only).
- in_code  input  8  scan code.
- in_ready  output  1  FIFO not full; a transfer occurs when in_valid & in_ready.
- ps2_clk  output  1  PS/2 clock to host; idle high.
- ps2_data  output  1  PS/2 data to host; idle high.
- busy  output  1  high while a frame or gap is in progress, or the FIFO is non-empty.
- frame_done  output  1  one-cycle pulse in the cycle the GAP state completes for each frame.

Behaviour:
- Reset values: ps2_clk=1, ps2_data=1, busy=0, frame_done=0, in_ready=1. FIFO emptied; FSM in IDLE.
- Reset is asynchronous. Asserting it mid-frame forces both lines high in the same cycle and discards the partial frame and all FIFO contents.
- All outputs are registered; there is no combinational path from inputs to ps2_*.
- FIFO behaviour:
  - Entry format is {brk, code}; pointers wrap modulo DEPTH.
  - When full, in_ready=0 and in_valid is ignored.
  - Simultaneous push and pop while full is not permitted: in_ready=0 blocks the push.
  - Simultaneous push and pop while empty is not permitted: a pop requires non-empty.
- Frame format: start bit 0, then data bits d0..d7 (LSB first), then odd parity P = ~^data, then stop bit 1. 11 bits total.
- FSM states:
  - IDLE: lines high. If the FIFO is non-empty, pop the head entry. If brk=1, load 0xF0 as the current byte and hold the code as pending. If brk=0, load the code. Set bit index 0 and go to BIT_HI.
  - BIT_HI: ps2_data = bit[idx], ps2_clk=1, held for HALF cycles. Data changes only on entry to BIT_HI, i.e. while ps2_clk is high. Then go to BIT_LO.
  - BIT_LO: ps2_clk=0, ps2_data unchanged, held for HALF cycles. The host samples on this falling edge. If idx=10, go to GAP; otherwise idx+1 and go to BIT_HI.
  - GAP: ps2_clk=1, ps2_data=1 for GAP cycles. frame_done pulses on the last GAP cycle. If a pending code exists, load it, clear pending and go to BIT_HI. Otherwise go to IDLE.
- Timing:
  - The first BIT_HI cycle is the cycle after the pop.
  - One frame occupies 22*HALF + GAP cycles (96 with defaults).
  - A break entry occupies two frames back-to-back, with no IDLE cycle between them.
- busy is high from the pop until IDLE is re-entered with the FIFO empty. A push into an empty FIFO also raises busy the next cycle.
- Inputs arriving during a frame only fill the FIFO; the frame in progress is never altered.

Test Plan:
- Make 0x1C, defaults → ps2_data sampled at 11 falling edges = 0,0,0,1,1,1,0,0,0,0(parity),1. Exactly 11 falling edges. frame_done pulses once, 96 cycles after the pop.
- Break 0x1C → first frame F0 (bits 0,0,0,0,0,1,1,1,1,1,1; parity=1), then frame 1C. Falling-edge spacing = 2*HALF inside frames and 2*HALF+GAP between the stop and the next start. Two frame_done pulses.
- Push 5 entries on consecutive cycles while the FSM is busy → in_ready drops after the 4th accepted entry and the 5th is dropped. Frames emerge in push order. busy falls only after the last GAP.
- Assert reset during bit 4 of a frame → ps2_clk and ps2_data go high combinationally with reset. After release: no further edges, busy=0, in_ready=1.
- Loopback into the host receiver (same clk, resetn = ~reset) with the sequence 0x1C, then brk 0x1C → receiver scan outputs 1C, F0, 1C; the receiver's release flag asserts on the final byte.
- HALF=2, GAP=0 → a 44-cycle frame. Back-to-back entries produce a continuous edge train with the correct parity.

Source files
------------

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queues {brk, code} entries and serialises
// them as 11-bit PS/2 frames, prefixing break entries with an F0 frame.
module ps2_kbd_tx #(
  parameter int HALF  = 4,
  parameter int GAP   = 8,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_brk,
  input  logic [7:0] in_code,
  output logic       in_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       frame_done,
  output logic [1:0] dbg_state
);

  // Handshake: an entry transfers on a rising clk edge where in_valid && in_ready;
  // in_ready is registered and low only while the FIFO is full.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = 16;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
  localparam logic [CW-1:0] GAP_PRE   = CW'(GAP - 2);
  localparam logic [PW:0]   FULL_CNT  = DEPTH[PW:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BIT_HI = 2'd1,
    S_BIT_LO = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    idx_q;
  logic [10:0]   frame_q;
  logic          pend_q;
  logic [7:0]    pend_code_q;
  logic          ps2_clk_q, ps2_data_q, busy_q, frame_done_q, in_ready_q;

  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          push, pop, end_frame;
  logic [8:0]    head;

  function automatic logic [10:0] mk_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    push    = in_valid && in_ready_q;
    pop     = (state_q == S_IDLE) && (count_q != '0);
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // With GAP == 0 the frame ends directly on the last low half of the stop bit.
  always_comb begin
    end_frame = 1'b0;
    if (state_q == S_GAP && cnt_q == GAP_LAST) begin
      end_frame = 1'b1;
    end else if (GAP == 0 && state_q == S_BIT_LO && idx_q == 4'd10 && cnt_q == HALF_LAST) begin
      end_frame = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_brk, in_code};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      in_ready_q <= (count_d != FULL_CNT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_q      <= '1;
      pend_q       <= 1'b0;
      pend_code_q  <= '0;
      ps2_clk_q    <= 1'b1;
      ps2_data_q   <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      busy_q       <= (state_q != S_IDLE) || (count_d != '0);
      if (end_frame) begin
        cnt_q        <= '0;
        idx_q        <= '0;
        ps2_clk_q    <= 1'b1;
        frame_done_q <= (GAP == 0);
        if (pend_q) begin
          frame_q    <= mk_frame(pend_code_q);
          pend_q     <= 1'b0;
          ps2_data_q <= 1'b0;
          state_q    <= S_BIT_HI;
        end else begin
          ps2_data_q <= 1'b1;
          state_q    <= S_IDLE;
          busy_q     <= (count_d != '0);
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (pop) begin
              frame_q     <= mk_frame(head[8] ? 8'hF0 : head[7:0]);
              pend_q      <= head[8];
              pend_code_q <= head[7:0];
              idx_q       <= '0;
              cnt_q       <= '0;
              ps2_clk_q   <= 1'b1;
              ps2_data_q  <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= S_BIT_HI;
            end
          end
          S_BIT_HI: begin
            if (cnt_q == HALF_LAST) begin
              cnt_q     <= '0;
              ps2_clk_q <= 1'b0;
              state_q   <= S_BIT_LO;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_BIT_LO: begin
            if (cnt_q == HALF_LAST) begin
              cnt_q     <= '0;
              ps2_clk_q <= 1'b1;
              if (idx_q == 4'd10) begin
                ps2_data_q   <= 1'b1;
                frame_done_q <= (GAP == 1);
                state_q      <= S_GAP;
              end else begin
                idx_q      <= idx_q + 4'd1;
                ps2_data_q <= frame_q[idx_q + 4'd1];
                state_q    <= S_BIT_HI;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_GAP: begin
            cnt_q        <= cnt_q + 1'b1;
            frame_done_q <= (cnt_q == GAP_PRE);
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule
